// File: rtl/gpu_pixel_serializer.sv
// gpu_pixel_serializer
// Turns bitplane bytes returned by the GPU RAM read port into one 8-bit
// palette index per pixel tick. A byte holds 8/4/2/1 pixels at 1/2/4/8 bpp.
// The datapath has two stages: a shifter that is being drained, and one
// preload slot behind it. Each byte carries its own bpp, mirror and palette
// base, so a mode change takes effect exactly at the byte boundary.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   pc_ena_in    pixel-clock-enable bus; bit TICK_BIT is the pixel tick
//   data_in      pixel byte from RAM port A (aligned with cmd_in/pc_ena_in)
//   cmd_in       [1:0] bpp code, [2] mirror, [3] load, [7:4] palette base,
//                [15] flush; all other bits are ignored
//   clr_status   clears the sticky underrun/overrun flags
//   pixel_out    palette index; holds its value while pixel_valid is low
//   pixel_valid  one-cycle strobe per consumed tick
//   pc_ena_out   pc_ena_in delayed one clock, aligned with pixel_out
//   byte_req     registered "preload slot is empty" hint
//   underrun     sticky: a tick found no pixel left
//   overrun      sticky: a load was dropped because both stages were full
//
// Flow control: there is no valid/ready handshake. cmd_in[3] (load) is an
// unconditional valid; the block accepts the byte if the shifter (after this
// cycle's tick) or the preload slot has room, otherwise it drops the byte and
// raises overrun. byte_req is only a hint that one more byte fits; upstream
// is expected to respect it, and overrun records when it did not.
module gpu_pixel_serializer #(
   parameter logic [7:0] BG_INDEX = 8'h00,
   parameter int         TICK_BIT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  pc_ena_in,
   input  logic [7:0]  data_in,
   input  logic [15:0] cmd_in,
   input  logic        clr_status,
   output logic [7:0]  pixel_out,
   output logic        pixel_valid,
   output logic [3:0]  pc_ena_out,
   output logic        byte_req,
   output logic        underrun,
   output logic        overrun
);

   // Shifter stage
   logic [7:0] sh_data, n_sh_data;
   logic [3:0] sh_count, n_sh_count;
   logic [1:0] sh_bpp, n_sh_bpp;
   logic       sh_mirror, n_sh_mirror;
   logic [3:0] sh_base, n_sh_base;
   // Preload stage
   logic [7:0] pre_data, n_pre_data;
   logic [1:0] pre_bpp, n_pre_bpp;
   logic       pre_mirror, n_pre_mirror;
   logic [3:0] pre_base, n_pre_base;
   logic       pre_valid, n_pre_valid;

   logic [7:0] n_pixel;
   logic [7:0] raw_pix, fmt_pix, shifted;
   logic       flush, tick, load, und_set, ovr_set;
   logic       unused_cmd;

   assign flush      = cmd_in[15];
   assign load       = cmd_in[3];
   // A flush suppresses the tick entirely: no pixel and no underrun.
   assign tick       = pc_ena_in[TICK_BIT] & ~flush;
   assign unused_cmd = ^cmd_in[14:8];

   function automatic logic [3:0] pix_per_byte(input logic [1:0] code);
      case (code)
         2'd0:    pix_per_byte = 4'd8;
         2'd1:    pix_per_byte = 4'd4;
         2'd2:    pix_per_byte = 4'd2;
         default: pix_per_byte = 4'd1;
      endcase
   endfunction

   // Pixel extraction from the shifter: normal order takes the top bits and
   // shifts left, mirror order takes the bottom bits and shifts right.
   always_comb begin
      raw_pix = 8'h00;
      shifted = sh_data;
      case (sh_bpp)
         2'd0: begin
            raw_pix = sh_mirror ? {7'd0, sh_data[0]} : {7'd0, sh_data[7]};
            shifted = sh_mirror ? (sh_data >> 1) : (sh_data << 1);
         end
         2'd1: begin
            raw_pix = sh_mirror ? {6'd0, sh_data[1:0]} : {6'd0, sh_data[7:6]};
            shifted = sh_mirror ? (sh_data >> 2) : (sh_data << 2);
         end
         2'd2: begin
            raw_pix = sh_mirror ? {4'd0, sh_data[3:0]} : {4'd0, sh_data[7:4]};
            shifted = sh_mirror ? (sh_data >> 4) : (sh_data << 4);
         end
         default: begin
            raw_pix = sh_data;
            shifted = 8'h00;
         end
      endcase
      // 8 bpp is a direct index; narrower modes sit inside a 16-entry bank.
      fmt_pix = (sh_bpp == 2'd3) ? raw_pix : {sh_base, raw_pix[3:0]};
   end

   // Next-state: flush, then tick, then preload->shifter, then load.
   always_comb begin
      n_sh_data    = sh_data;
      n_sh_count   = sh_count;
      n_sh_bpp     = sh_bpp;
      n_sh_mirror  = sh_mirror;
      n_sh_base    = sh_base;
      n_pre_data   = pre_data;
      n_pre_bpp    = pre_bpp;
      n_pre_mirror = pre_mirror;
      n_pre_base   = pre_base;
      n_pre_valid  = pre_valid;
      n_pixel      = pixel_out;
      und_set      = 1'b0;
      ovr_set      = 1'b0;

      if (flush) begin
         n_sh_count  = 4'd0;
         n_pre_valid = 1'b0;
      end

      if (tick) begin
         if (n_sh_count != 4'd0) begin
            n_pixel    = fmt_pix;
            n_sh_data  = shifted;
            n_sh_count = n_sh_count - 4'd1;
         end else begin
            n_pixel = BG_INDEX;
            und_set = 1'b1;
         end
      end

      if (n_sh_count == 4'd0 && n_pre_valid) begin
         n_sh_data   = pre_data;
         n_sh_bpp    = pre_bpp;
         n_sh_mirror = pre_mirror;
         n_sh_base   = pre_base;
         n_sh_count  = pix_per_byte(pre_bpp);
         n_pre_valid = 1'b0;
      end

      if (load) begin
         if (n_sh_count == 4'd0) begin
            n_sh_data   = data_in;
            n_sh_bpp    = cmd_in[1:0];
            n_sh_mirror = cmd_in[2];
            n_sh_base   = cmd_in[7:4];
            n_sh_count  = pix_per_byte(cmd_in[1:0]);
         end else if (!n_pre_valid) begin
            n_pre_data   = data_in;
            n_pre_bpp    = cmd_in[1:0];
            n_pre_mirror = cmd_in[2];
            n_pre_base   = cmd_in[7:4];
            n_pre_valid  = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_data     <= 8'h00;
         sh_count    <= 4'd0;
         sh_bpp      <= 2'd0;
         sh_mirror   <= 1'b0;
         sh_base     <= 4'd0;
         pre_data    <= 8'h00;
         pre_bpp     <= 2'd0;
         pre_mirror  <= 1'b0;
         pre_base    <= 4'd0;
         pre_valid   <= 1'b0;
         pixel_out   <= 8'h00;
         pixel_valid <= 1'b0;
         pc_ena_out  <= 4'd0;
         byte_req    <= 1'b0;
         underrun    <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         sh_data     <= n_sh_data;
         sh_count    <= n_sh_count;
         sh_bpp      <= n_sh_bpp;
         sh_mirror   <= n_sh_mirror;
         sh_base     <= n_sh_base;
         pre_data    <= n_pre_data;
         pre_bpp     <= n_pre_bpp;
         pre_mirror  <= n_pre_mirror;
         pre_base    <= n_pre_base;
         pre_valid   <= n_pre_valid;
         pixel_out   <= n_pixel;
         pixel_valid <= tick;
         pc_ena_out  <= pc_ena_in;
         byte_req    <= ~n_pre_valid;
         // A new event in the same cycle as clr_status keeps the flag set.
         underrun    <= und_set | (underrun & ~clr_status);
         overrun     <= ovr_set | (overrun & ~clr_status);
      end
   end

endmodule

// File: tb/tb_gpu_pixel_serializer.sv
module tb_gpu_pixel_serializer;

   localparam logic [7:0] BG  = 8'h00;
   localparam int         TBIT = 0;

   logic        clk;
   logic        rst_n;
   logic [3:0]  pc_ena_in;
   logic [7:0]  data_in;
   logic [15:0] cmd_in;
   logic        clr_status;
   logic [7:0]  pixel_out;
   logic        pixel_valid;
   logic [3:0]  pc_ena_out;
   logic        byte_req;
   logic        underrun;
   logic        overrun;

   gpu_pixel_serializer #(.BG_INDEX(BG), .TICK_BIT(TBIT)) dut (
      .clk(clk), .rst_n(rst_n), .pc_ena_in(pc_ena_in), .data_in(data_in),
      .cmd_in(cmd_in), .clr_status(clr_status), .pixel_out(pixel_out),
      .pixel_valid(pixel_valid), .pc_ena_out(pc_ena_out), .byte_req(byte_req),
      .underrun(underrun), .overrun(overrun)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_bad;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic tick, input logic load, input logic flush,
                        input logic clr, input logic [1:0] bpp, input logic mir,
                        input logic [3:0] base, input logic [7:0] data,
                        input logic [3:0] other_pce);
      logic [3:0]  p;
      logic [6:0]  junk;
      p       = other_pce;
      p[TBIT] = tick;
      junk    = 7'($urandom);
      pc_ena_in  = p;
      cmd_in     = {flush, junk, base, load, mir, bpp};
      data_in    = data;
      clr_status = clr;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       tick, load, flush, clr;
      logic [1:0] bpp;
      logic       mir;
      logic [3:0] base;
      logic [7:0] data;
      logic       e_valid;
      logic [7:0] e_pix;
      logic       e_breq, e_und, e_ovr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic tick, input logic load, input logic flush,
                              input logic clr, input logic [1:0] bpp, input logic mir,
                              input logic [3:0] base, input logic [7:0] data,
                              input logic ev, input logic [7:0] ep, input logic eb,
                              input logic eu, input logic eo);
      vec_t r;
      r.tick = tick; r.load = load; r.flush = flush; r.clr = clr;
      r.bpp = bpp; r.mir = mir; r.base = base; r.data = data;
      r.e_valid = ev; r.e_pix = ep; r.e_breq = eb; r.e_und = eu; r.e_ovr = eo;
      return r;
   endfunction

   // ---------------- reference model ----------------
   // The shifter is a queue of ready-made palette indices; the preload is a
   // raw byte plus its command word, expanded only when it moves forward.
   int          m_q[$];
   logic        m_pre_v;
   logic [7:0]  m_pre_d;
   logic [15:0] m_pre_c;
   logic [7:0]  m_pix;
   logic        m_valid, m_und, m_ovr, m_breq;
   logic [3:0]  m_pce;

   task automatic m_expand(input logic [7:0] d, input logic [15:0] c);
      int w, mask, val;
      w    = 1 << int'(c[1:0]);
      mask = (1 << w) - 1;
      for (int i = 0; i < 8 / w; i++) begin
         if (c[2]) val = (int'(d) >> (w * i)) & mask;
         else      val = (int'(d) >> (8 - w * (i + 1))) & mask;
         if (w == 8) m_q.push_back(val);
         else        m_q.push_back(int'(c[7:4]) * 16 + val);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_pre_v = 1'b0; m_pre_d = 8'h00; m_pre_c = 16'h0000;
      m_pix = 8'h00; m_valid = 1'b0; m_und = 1'b0; m_ovr = 1'b0;
      m_breq = 1'b0; m_pce = 4'h0;
   endtask

   task automatic m_step(input logic [3:0] pce, input logic [7:0] d,
                         input logic [15:0] c, input logic clr);
      logic us, os;
      us = 1'b0; os = 1'b0;
      m_valid = 1'b0;
      if (c[15]) begin
         m_q.delete();
         m_pre_v = 1'b0;
      end else if (pce[TBIT]) begin
         m_valid = 1'b1;
         if (m_q.size() > 0) m_pix = 8'(m_q.pop_front());
         else begin
            m_pix = BG;
            us = 1'b1;
         end
      end
      if (m_q.size() == 0 && m_pre_v) begin
         m_expand(m_pre_d, m_pre_c);
         m_pre_v = 1'b0;
      end
      if (c[3]) begin
         if (m_q.size() == 0) m_expand(d, c);
         else if (!m_pre_v) begin
            m_pre_v = 1'b1; m_pre_d = d; m_pre_c = c;
         end else os = 1'b1;
      end
      m_und  = us | (m_und & ~clr);
      m_ovr  = os | (m_ovr & ~clr);
      m_breq = ~m_pre_v;
      m_pce  = pce;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [3:0]  rp;
      logic [7:0]  rd;
      logic [15:0] rc;
      logic        rclr;
      logic [7:0]  exp1;

      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      pc_ena_in = 4'h0; data_in = 8'h00; cmd_in = 16'h0000; clr_status = 1'b0;

      // Test 1: 1bpp base 3, byte A5
      vecs.push_back(v(0,1,0,0, 2'd0,0,4'h3,8'hA5, 0,8'h00,1,0,0));
      exp1 = 8'hA5;
      for (int i = 0; i < 8; i++)
         vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1, {4'h3, 3'b000, exp1[7-i]}, 1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h00,1,1,0));
      vecs.push_back(v(0,0,0,1, 2'd0,0,4'h0,8'h00, 0,8'h00,1,0,0));
      // Test 2: 2bpp mirror, byte E4
      vecs.push_back(v(0,1,0,0, 2'd1,1,4'h0,8'hE4, 0,8'h00,1,0,0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1, 8'(i), 1,0,0));
      // Test 3: 8bpp double buffering and byte_req
      vecs.push_back(v(0,1,0,0, 2'd3,0,4'h0,8'h12, 0,8'h03,1,0,0));
      vecs.push_back(v(0,1,0,0, 2'd3,0,4'h0,8'h34, 0,8'h03,0,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h12,1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h34,1,0,0));
      // Test 4: overrun on the third load
      vecs.push_back(v(0,1,0,0, 2'd3,0,4'h0,8'h56, 0,8'h34,1,0,0));
      vecs.push_back(v(0,1,0,0, 2'd3,0,4'h0,8'h78, 0,8'h34,0,0,0));
      vecs.push_back(v(0,1,0,0, 2'd3,0,4'h0,8'h9A, 0,8'h34,0,0,1));
      vecs.push_back(v(0,0,0,1, 2'd0,0,4'h0,8'h00, 0,8'h34,0,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h56,1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h78,1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h00,1,1,0));
      vecs.push_back(v(0,0,0,1, 2'd0,0,4'h0,8'h00, 0,8'h00,1,0,0));
      // Test 5: flush + load in one cycle discards the old nibble
      vecs.push_back(v(0,1,0,0, 2'd2,0,4'h0,8'h7C, 0,8'h00,1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h07,1,0,0));
      vecs.push_back(v(0,1,1,0, 2'd2,0,4'h0,8'h3D, 0,8'h07,1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h03,1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h0D,1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h00,1,1,0));
      vecs.push_back(v(0,0,0,1, 2'd0,0,4'h0,8'h00, 0,8'h00,1,0,0));
      // Same-cycle tick+load: the tick underruns, the byte is kept
      vecs.push_back(v(1,1,0,0, 2'd3,0,4'h0,8'hAB, 1,8'h00,1,1,0));
      vecs.push_back(v(1,0,0,1, 2'd0,0,4'h0,8'h00, 1,8'hAB,1,0,0));
      // Set beats clear
      vecs.push_back(v(1,0,0,1, 2'd0,0,4'h0,8'h00, 1,8'h00,1,1,0));
      vecs.push_back(v(0,0,0,1, 2'd0,0,4'h0,8'h00, 0,8'h00,1,0,0));
      // Flush with tick: no pixel, no underrun
      vecs.push_back(v(0,1,0,0, 2'd3,0,4'h0,8'hEE, 0,8'h00,1,0,0));
      vecs.push_back(v(1,0,1,0, 2'd0,0,4'h0,8'h00, 0,8'h00,1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h00,1,1,0));
      vecs.push_back(v(0,0,0,1, 2'd0,0,4'h0,8'h00, 0,8'h00,1,0,0));
      // Attributes travel with the preloaded byte
      vecs.push_back(v(0,1,0,0, 2'd0,0,4'h5,8'h80, 0,8'h00,1,0,0));
      vecs.push_back(v(0,1,0,0, 2'd3,0,4'h9,8'hC3, 0,8'h00,0,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h51,0,0,0));
      for (int i = 0; i < 6; i++)
         vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h50,0,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'h50,1,0,0));
      vecs.push_back(v(1,0,0,0, 2'd0,0,4'h0,8'h00, 1,8'hC3,1,0,0));

      // ---- reset state ----
      #2;
      check("rst_pix",   pixel_out, 8'h00);
      check("rst_valid", {7'd0, pixel_valid}, 8'h00);
      check("rst_pce",   {4'd0, pc_ena_out}, 8'h00);
      check("rst_breq",  {7'd0, byte_req}, 8'h00);
      check("rst_und",   {7'd0, underrun}, 8'h00);
      check("rst_ovr",   {7'd0, overrun}, 8'h00);
      #10 rst_n = 1'b1;
      step();
      check("post_rst_breq", {7'd0, byte_req}, 8'h01);

      // ---- table ----
      foreach (vecs[k]) begin
         logic [3:0] op;
         op = 4'($urandom);
         drive(vecs[k].tick, vecs[k].load, vecs[k].flush, vecs[k].clr, vecs[k].bpp,
               vecs[k].mir, vecs[k].base, vecs[k].data, op);
         step();
         check($sformatf("vec%0d_valid", k), {7'd0, pixel_valid}, {7'd0, vecs[k].e_valid});
         check($sformatf("vec%0d_pix", k),   pixel_out, vecs[k].e_pix);
         check($sformatf("vec%0d_breq", k),  {7'd0, byte_req}, {7'd0, vecs[k].e_breq});
         check($sformatf("vec%0d_und", k),   {7'd0, underrun}, {7'd0, vecs[k].e_und});
         check($sformatf("vec%0d_ovr", k),   {7'd0, overrun}, {7'd0, vecs[k].e_ovr});
         check($sformatf("vec%0d_pce", k),   {4'd0, pc_ena_out}, {4'd0, pc_ena_in});
      end

      // ---- asynchronous reset mid-byte ----
      drive(0,1,0,0, 2'd3,0,4'h0,8'h5A, 4'h0); step();
      drive(0,1,0,0, 2'd3,0,4'h0,8'h77, 4'h0); step();
      drive(0,1,0,0, 2'd3,0,4'h0,8'h99, 4'h0); step();
      drive(1,0,0,0, 2'd0,0,4'h0,8'h00, 4'hF); step();
      check("pre_rst_pix", pixel_out, 8'h5A);
      check("pre_rst_ovr", {7'd0, overrun}, 8'h01);
      drive(0,0,0,0, 2'd0,0,4'h0,8'h00, 4'h0);
      #3 rst_n = 1'b0;
      #1;
      check("arst_pix",   pixel_out, 8'h00);
      check("arst_valid", {7'd0, pixel_valid}, 8'h00);
      check("arst_pce",   {4'd0, pc_ena_out}, 8'h00);
      check("arst_breq",  {7'd0, byte_req}, 8'h00);
      check("arst_und",   {7'd0, underrun}, 8'h00);
      check("arst_ovr",   {7'd0, overrun}, 8'h00);
      #7 rst_n = 1'b1;
      step();
      check("arst_rel_breq", {7'd0, byte_req}, 8'h01);
      check("arst_rel_und",  {7'd0, underrun}, 8'h00);
      drive(1,0,0,0, 2'd0,0,4'h0,8'h00, 4'h0); step();
      check("arst_tick_valid", {7'd0, pixel_valid}, 8'h01);
      check("arst_tick_pix",   pixel_out, BG);
      check("arst_tick_und",   {7'd0, underrun}, 8'h01);

      // ---- randomized run against the model ----
      drive(0,0,0,0, 2'd0,0,4'h0,8'h00, 4'h0);
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      m_reset();
      m_step(4'h0, 8'h00, 16'h0000, 1'b0);
      step();
      for (int i = 0; i < 3000; i++) begin
         rp     = 4'($urandom);
         rd     = 8'($urandom);
         rc     = 16'($urandom);
         rc[15] = ($urandom_range(0, 19) == 0);
         rc[3]  = ($urandom_range(0, 2) == 0);
         rclr   = ($urandom_range(0, 15) == 0);
         pc_ena_in = rp; data_in = rd; cmd_in = rc; clr_status = rclr;
         m_step(rp, rd, rc, rclr);
         step();
         check($sformatf("rnd%0d_valid", i), {7'd0, pixel_valid}, {7'd0, m_valid});
         check($sformatf("rnd%0d_pix", i),   pixel_out, m_pix);
         check($sformatf("rnd%0d_breq", i),  {7'd0, byte_req}, {7'd0, m_breq});
         check($sformatf("rnd%0d_und", i),   {7'd0, underrun}, {7'd0, m_und});
         check($sformatf("rnd%0d_ovr", i),   {7'd0, overrun}, {7'd0, m_ovr});
         check($sformatf("rnd%0d_pce", i),   {4'd0, pc_ena_out}, {4'd0, m_pce});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
